// File: rtl/mc_control.sv
// mc_control: multi-cycle sequencer for the 16-bit, 4-register CPU datapath.
// It steps one shared ALU through fetch, decode, execute and writeback, runs
// the instruction-memory request/ready handshake and drives every datapath
// write enable. Outputs decode the registered state, the opcode and, in FETCH
// only, imem_ready.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | stopped; waits for run
// FETCH  | request instruction; on imem_ready load IR and PC <= PC + PC_INC
// DECODE | latch A/B; route arithmetic ops, HALT_OP, or flag an illegal op
// EXEC   | ALU works on A and B/immediate; result latched into ALUOut
// WB     | ALUOut written to the register file; instruction retires
// HALT   | halted; left only through reset

module mc_control #(
    parameter logic [3:0] HALT_OP = 4'b1111,
    parameter int         PC_INC  = 2,
    parameter int         TIMEOUT = 15,
    parameter int         CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [3:0]       instr_op,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             ab_write,
    output logic             aluout_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_sel_a,
    output logic [1:0]       alu_sel_b,
    output logic [3:0]       alu_ctl,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic             fetch_err,
    output logic [CNT_W-1:0] instr_count
);

    // The PC is a byte address of 16-bit instructions, so the step must be even.
    if ((PC_INC <= 0) || ((PC_INC % 2) != 0)) begin : g_bad_pc_inc
        $error("mc_control: PC_INC must be a positive even byte step");
    end

    // Fetch wait timer: down-counter loaded on entry to FETCH; the FETCH cycle
    // that sees it at zero with no imem_ready is the TIMEOUT-th wait cycle.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    localparam logic [3:0] OP_ADDI = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    function automatic logic [3:0] op_alu_ctl(input logic [3:0] op);
        logic [3:0] ctl;
        ctl = 4'b0000;
        case (op)
            4'b0000: ctl = 4'b0010;  // ADD
            4'b0001: ctl = 4'b0110;  // SUB
            4'b0010: ctl = 4'b0000;  // AND
            4'b0011: ctl = 4'b0001;  // OR
            4'b0100: ctl = 4'b1100;  // NOR
            4'b0101: ctl = 4'b1101;  // NAND
            4'b0110: ctl = 4'b0111;  // SLT
            4'b0111: ctl = 4'b0010;  // ADDI
            default: ctl = 4'b0000;
        endcase
        return ctl;
    endfunction

    // State sequencing, fetch wait timer, sticky flags and retired-instruction count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= WAIT_LOAD;
            illegal     <= 1'b0;
            fetch_err   <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_FETCH;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        state <= S_DECODE;
                    end else if ((TIMEOUT > 0) && (wait_cnt == '0)) begin
                        fetch_err <= 1'b1;
                        state     <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_DECODE: begin
                    if (instr_op == HALT_OP) begin
                        state <= S_HALT;
                        if (instr_count != '1) begin
                            instr_count <= instr_count + 1'b1;
                        end
                    end else if (!instr_op[3]) begin
                        state <= S_EXEC;
                    end else begin
                        // Undefined opcode: dropped without retiring.
                        illegal <= 1'b1;
                        if (run) begin
                            state    <= S_FETCH;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_EXEC: begin
                    state <= S_WB;
                end
                S_WB: begin
                    if (instr_count != '1) begin
                        instr_count <= instr_count + 1'b1;
                    end
                    if (run) begin
                        state    <= S_FETCH;
                        wait_cnt <= WAIT_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath controls decoded from the current state and opcode.
    always_comb begin
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        ab_write     = 1'b0;
        aluout_write = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        alu_sel_a    = 1'b0;
        alu_sel_b    = 2'b00;
        alu_ctl      = 4'b0000;
        halted       = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req  = 1'b1;
                alu_sel_a = 1'b1;
                alu_sel_b = 2'b01;
                alu_ctl   = 4'b0010;
                ir_write  = imem_ready;
                pc_write  = imem_ready;
            end
            S_DECODE: begin
                ab_write = 1'b1;
            end
            S_EXEC: begin
                aluout_write = 1'b1;
                alu_sel_b    = (instr_op == OP_ADDI) ? 2'b10 : 2'b00;
                alu_ctl      = op_alu_ctl(instr_op);
            end
            S_WB: begin
                reg_write = 1'b1;
                reg_dst   = (instr_op != OP_ADDI);
                alu_sel_b = (instr_op == OP_ADDI) ? 2'b10 : 2'b00;
                alu_ctl   = op_alu_ctl(instr_op);
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy = (state != S_IDLE) && (state != S_HALT);

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: reset, back-to-back arithmetic, fetch wait
// states, run drop mid-instruction, reset mid-EXEC, illegal opcode, HALT and
// fetch timeout.

module tb_mc_control;

    logic        clock;
    logic        reset;
    logic        run;
    logic [3:0]  instr_op;
    logic        imem_ready;
    logic        imem_req;
    logic        ir_write;
    logic        pc_write;
    logic        ab_write;
    logic        aluout_write;
    logic        reg_write;
    logic        reg_dst;
    logic        alu_sel_a;
    logic [1:0]  alu_sel_b;
    logic [3:0]  alu_ctl;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic        fetch_err;
    logic [15:0] instr_count;

    int checks   = 0;
    int failures = 0;

    mc_control dut (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .instr_op     (instr_op),
        .imem_ready   (imem_ready),
        .imem_req     (imem_req),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .ab_write     (ab_write),
        .aluout_write (aluout_write),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .alu_sel_a    (alu_sel_a),
        .alu_sel_b    (alu_sel_b),
        .alu_ctl      (alu_ctl),
        .busy         (busy),
        .halted       (halted),
        .illegal      (illegal),
        .fetch_err    (fetch_err),
        .instr_count  (instr_count)
    );

    // {imem_req, ir_write, pc_write, ab_write, aluout_write, reg_write}
    logic [5:0] en_vec;
    // {alu_sel_a, alu_sel_b, alu_ctl}
    logic [6:0] alu_vec;
    // {busy, halted, illegal, fetch_err}
    logic [3:0] flag_vec;

    assign en_vec   = {imem_req, ir_write, pc_write, ab_write, aluout_write, reg_write};
    assign alu_vec  = {alu_sel_a, alu_sel_b, alu_ctl};
    assign flag_vec = {busy, halted, illegal, fetch_err};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts in FETCH with imem_ready=1 and ends with the WB cycle checked.
    task automatic do_instr(input string tag, input logic [3:0] op,
                            input logic [6:0] alu_exp, input logic dst_exp);
        check({tag, "_fetch_en"},  32'(en_vec),  32'(6'b111000));
        check({tag, "_fetch_alu"}, 32'(alu_vec), 32'(7'b1_01_0010));
        instr_op = op;
        tick();
        check({tag, "_decode_en"}, 32'(en_vec),  32'(6'b000100));
        tick();
        check({tag, "_exec_en"},   32'(en_vec),  32'(6'b000010));
        check({tag, "_exec_alu"},  32'(alu_vec), 32'(alu_exp));
        tick();
        check({tag, "_wb_en"},     32'(en_vec),  32'(6'b000001));
        check({tag, "_wb_alu"},    32'(alu_vec), 32'(alu_exp));
        check({tag, "_wb_dst"},    32'(reg_dst), 32'(dst_exp));
    endtask

    initial begin
        reset      = 1'b1;
        run        = 1'b0;
        imem_ready = 1'b0;
        instr_op   = 4'b0000;

        // Reset state
        tick();
        check("rst_en",    32'(en_vec),      32'h0);
        check("rst_alu",   32'(alu_vec),     32'h0);
        check("rst_dst",   32'(reg_dst),     32'h0);
        check("rst_flags", 32'(flag_vec),    32'h0);
        check("rst_count", 32'(instr_count), 32'h0);
        reset = 1'b0;
        tick();
        check("idle_norun_flags", 32'(flag_vec), 32'h0);

        // Back-to-back ADDI, SUB, OR, SLT with no wait states
        run        = 1'b1;
        imem_ready = 1'b1;
        tick();
        do_instr("addi", 4'b0111, 7'b0_10_0010, 1'b0);
        tick();
        do_instr("sub",  4'b0001, 7'b0_00_0110, 1'b1);
        tick();
        do_instr("or",   4'b0011, 7'b0_00_0001, 1'b1);
        tick();
        do_instr("slt",  4'b0110, 7'b0_00_0111, 1'b1);
        run = 1'b0;
        tick();
        check("b2b_count", 32'(instr_count), 32'd4);
        check("b2b_idle_flags", 32'(flag_vec), 32'h0);

        // Three wait states, then ADD with run dropped during EXEC
        run        = 1'b1;
        imem_ready = 1'b0;
        tick();
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("ws_wait%0d_en", i), 32'(en_vec), 32'(6'b100000));
            tick();
        end
        imem_ready = 1'b1;
        #1;
        check("ws_fetch4_en",  32'(en_vec),    32'(6'b111000));
        check("ws_fetch_err",  32'(fetch_err), 32'h0);
        instr_op = 4'b0000;
        tick();
        tick();
        check("drop_exec_en",  32'(en_vec),    32'(6'b000010));
        run = 1'b0;
        tick();
        check("drop_wb_en",    32'(en_vec),    32'(6'b000001));
        check("drop_wb_alu",   32'(alu_vec),   32'(7'b0_00_0010));
        check("drop_wb_dst",   32'(reg_dst),   32'h1);
        tick();
        check("drop_idle_en",  32'(en_vec),    32'h0);
        check("drop_idle_flags", 32'(flag_vec), 32'h0);
        check("drop_count",    32'(instr_count), 32'd5);
        run = 1'b1;
        tick();
        check("rerun_flags",   32'(flag_vec),  32'(4'b1000));
        check("rerun_fetch_en", 32'(en_vec),   32'(6'b111000));

        // Reset asserted in the middle of an EXEC cycle
        instr_op = 4'b0001;
        tick();
        tick();
        check("pre_rst_exec_en", 32'(en_vec), 32'(6'b000010));
        #1;
        reset = 1'b1;
        #1;
        check("midrst_en",    32'(en_vec),      32'h0);
        check("midrst_alu",   32'(alu_vec),     32'h0);
        check("midrst_flags", 32'(flag_vec),    32'h0);
        check("midrst_count", 32'(instr_count), 32'h0);
        tick();
        check("midrst_hold_en",    32'(en_vec),   32'h0);
        check("midrst_hold_flags", 32'(flag_vec), 32'h0);
        reset = 1'b0;

        // Illegal opcode followed by HALT_OP
        tick();
        check("ill_fetch_en", 32'(en_vec), 32'(6'b111000));
        instr_op = 4'b1010;
        tick();
        check("ill_decode_en",  32'(en_vec),  32'(6'b000100));
        check("ill_decode_ill", 32'(illegal), 32'h0);
        tick();
        check("ill_next_en",    32'(en_vec),   32'(6'b111000));
        check("ill_flags",      32'(flag_vec), 32'(4'b1010));
        check("ill_count",      32'(instr_count), 32'h0);
        instr_op = 4'b1111;
        tick();
        check("halt_decode_en", 32'(en_vec), 32'(6'b000100));
        tick();
        check("halt_en",    32'(en_vec),      32'h0);
        check("halt_flags", 32'(flag_vec),    32'(4'b0110));
        check("halt_count", 32'(instr_count), 32'd1);
        run = 1'b0;
        tick();
        check("halt_runlo_flags", 32'(flag_vec), 32'(4'b0110));
        run = 1'b1;
        tick();
        tick();
        check("halt_runhi_flags", 32'(flag_vec),    32'(4'b0110));
        check("halt_runhi_en",    32'(en_vec),      32'h0);
        check("halt_runhi_count", 32'(instr_count), 32'd1);

        // Fetch timeout with imem_ready held low
        run        = 1'b0;
        imem_ready = 1'b0;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        check("to_rst_flags", 32'(flag_vec), 32'h0);
        run = 1'b1;
        tick();
        for (int i = 1; i <= 15; i++) begin
            check($sformatf("to_wait%0d_en", i),    32'(en_vec),   32'(6'b100000));
            check($sformatf("to_wait%0d_flags", i), 32'(flag_vec), 32'(4'b1000));
            tick();
        end
        check("to_halt_en",    32'(en_vec),   32'h0);
        check("to_halt_flags", 32'(flag_vec), 32'(4'b0101));
        tick();
        check("to_halt_hold_flags", 32'(flag_vec), 32'(4'b0101));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
